// File: rtl/rstgen_pkg.sv
// Shared types and constants for the system-domain reset controller.
package rstgen_pkg;

  typedef enum logic [2:0] {
    RST_SYNC = 3'd0,
    RST_HOLD = 3'd1,
    RST_STEP = 3'd2,
    RST_RUN  = 3'd3,
    RST_SOFT = 3'd4
  } rst_state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rstgen_if.sv
// Request/status bundle between the reset controller and its consumers.
interface rstgen_if #(
  parameter int NumDomains = 3
);
  logic                  soft_rst_req_i;
  logic                  cause_clr_i;
  logic [NumDomains-1:0] rst_dom_no;
  logic                  rst_done_o;
  logic [1:0]            rst_cause_o;

  modport master (
    output soft_rst_req_i,
    output cause_clr_i,
    input  rst_dom_no,
    input  rst_done_o,
    input  rst_cause_o
  );

  modport slave (
    input  soft_rst_req_i,
    input  cause_clr_i,
    output rst_dom_no,
    output rst_done_o,
    output rst_cause_o
  );
endinterface

// File: rtl/rstgen_sync.sv
// Async-assert / sync-deassert release chain; rel goes high Stages edges after rst_n rises.
module rstgen_sync #(
  parameter int Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rel
);

  logic [Stages-1:0] chain_r;

  // Shift a constant one through the chain once reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[Stages-2:0], 1'b1};
    end
  end

  assign rel = chain_r[Stages-1];

endmodule

// File: rtl/rstgen_sys.sv
// System-domain reset controller: filters the raw reset, stretches it, releases
// domains in order and services soft-reset requests with a sticky cause record.
module rstgen_sys
  import rstgen_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int HoldCycles = 16,
  parameter int StepCycles = 4,
  parameter int NumDomains = 3
) (
  input logic      clk_sys,
  input logic      rst_sys_n,
  rstgen_if.slave  bus
);

  localparam int CntW    = $clog2(max_int(HoldCycles, StepCycles) + 1);
  localparam int IdxW    = $clog2(NumDomains);
  localparam int LastIdx = NumDomains - 1;

  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] HoldTerm = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] StepTerm = CntW'(StepCycles - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(LastIdx);

  rst_state_e            state_r;
  logic [CntW-1:0]       cnt_r;
  logic [IdxW-1:0]       idx_r;
  logic                  first_r;
  logic [NumDomains-1:0] dom_r;
  logic                  done_r;
  logic [1:0]            cause_r;
  logic                  sync_rel_s;
  logic                  soft_go_s;

  rstgen_sync #(.Stages(SyncStages)) u_sync (
    .clk   (clk_sys),
    .rst_n (rst_sys_n),
    .rel   (sync_rel_s)
  );

  // A soft request is honoured only once the synchronizer has released.
  assign soft_go_s = bus.soft_rst_req_i &&
                     ((state_r == RST_HOLD) || (state_r == RST_STEP) || (state_r == RST_RUN));

  // Sequencing FSM with shared counter, domain index and cause register.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_r <= RST_SYNC;
      cnt_r   <= '0;
      idx_r   <= '0;
      first_r <= 1'b0;
      dom_r   <= '0;
      done_r  <= 1'b0;
      cause_r <= CAUSE_EXT;
    end else begin
      if (soft_go_s) begin
        cause_r <= CAUSE_SOFT;
      end else if (bus.cause_clr_i) begin
        cause_r <= CAUSE_NONE;
      end else begin
        cause_r <= cause_r;
      end

      if (soft_go_s) begin
        // Domain 0 keeps its value; restart from it only if it was never released.
        state_r <= RST_SOFT;
        cnt_r   <= '0;
        first_r <= dom_r[0];
        dom_r   <= {{(NumDomains-1){1'b0}}, dom_r[0]};
        done_r  <= 1'b0;
      end else begin
        case (state_r)
          RST_SYNC: begin
            if (sync_rel_s) begin
              state_r <= RST_HOLD;
              cnt_r   <= '0;
              first_r <= 1'b0;
            end else begin
              cnt_r <= '0;
            end
          end
          RST_HOLD: begin
            if (cnt_r == HoldTerm) begin
              dom_r[IdxW'(first_r)] <= 1'b1;
              cnt_r <= '0;
              if (int'(first_r) == LastIdx) begin
                state_r <= RST_RUN;
                done_r  <= 1'b1;
              end else begin
                state_r <= RST_STEP;
                idx_r   <= IdxW'(first_r) + IdxW'(1);
              end
            end else begin
              cnt_r <= (cnt_r == CntMax) ? cnt_r : cnt_r + CntW'(1);
            end
          end
          RST_STEP: begin
            if (cnt_r == StepTerm) begin
              dom_r[idx_r] <= 1'b1;
              cnt_r <= '0;
              if (idx_r == IdxLast) begin
                state_r <= RST_RUN;
                done_r  <= 1'b1;
              end else begin
                idx_r <= idx_r + IdxW'(1);
              end
            end else begin
              cnt_r <= (cnt_r == CntMax) ? cnt_r : cnt_r + CntW'(1);
            end
          end
          RST_RUN: begin
            cnt_r <= '0;
          end
          RST_SOFT: begin
            cnt_r <= '0;
            if (!bus.soft_rst_req_i) begin
              state_r <= RST_HOLD;
            end else begin
              state_r <= RST_SOFT;
            end
          end
          default: begin
            state_r <= RST_SYNC;
            cnt_r   <= '0;
            dom_r   <= '0;
            done_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rst_dom_no  = dom_r;
  assign bus.rst_done_o  = done_r;
  assign bus.rst_cause_o = cause_r;

endmodule

// File: tb/tb_rstgen_sys.sv
// Self-checking bench for rstgen_sys: directed reset scenarios plus randomized
// traffic compared against a schedule-based reference model.
module tb_rstgen_sys;

  localparam int SS = 2;
  localparam int H  = 16;
  localparam int S  = 4;
  localparam int N  = 3;

  logic clk_sys   = 1'b0;
  logic rst_sys_n = 1'b0;

  rstgen_if #(.NumDomains(N)) bus ();

  rstgen_sys #(
    .SyncStages (SS),
    .HoldCycles (H),
    .StepCycles (S),
    .NumDomains (N)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .bus       (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: release times are computed from the sequence start edge.
  int         t       = 0;
  int         rise_t  = -1;
  int         seq_t0  = 0;
  int         m_first = 0;
  bit         m_wait  = 1'b1;
  bit         m_soft  = 1'b0;
  logic [N-1:0] e_dom  = '0;
  logic         e_done = 1'b0;
  logic [1:0]   e_cause = 2'b01;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, obs, expv, t);
    end
  endtask

  task automatic model_async_reset();
    e_dom   = '0;
    e_done  = 1'b0;
    e_cause = 2'b01;
    m_wait  = 1'b1;
    m_soft  = 1'b0;
    m_first = 0;
    rise_t  = -1;
  endtask

  task automatic model_step();
    bit soft_entry;
    soft_entry = 1'b0;
    t++;
    if (!rst_sys_n) begin
      model_async_reset();
      return;
    end
    if (m_wait) begin
      if (rise_t < 0) rise_t = t;
      if (t == rise_t + SS) begin
        m_wait  = 1'b0;
        seq_t0  = t;
        m_first = 0;
      end
    end else if (m_soft) begin
      if (!bus.soft_rst_req_i) begin
        m_soft = 1'b0;
        seq_t0 = t;
      end
    end else if (bus.soft_rst_req_i) begin
      m_soft     = 1'b1;
      soft_entry = 1'b1;
      m_first    = e_dom[0] ? 1 : 0;
      for (int d = 1; d < N; d++) e_dom[d] = 1'b0;
      e_done = 1'b0;
    end
    if (!m_wait && !m_soft) begin
      for (int d = 0; d < N; d++) begin
        if (d < m_first) e_dom[d] = 1'b1;
        else e_dom[d] = (t >= seq_t0 + H + (d - m_first) * S);
      end
      e_done = &e_dom;
    end
    if (soft_entry) e_cause = 2'b10;
    else if (bus.cause_clr_i) e_cause = 2'b00;
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    model_step();
    #1;
    check_eq("dom",   32'(bus.rst_dom_no),  32'(e_dom));
    check_eq("done",  32'(bus.rst_done_o),  32'(e_done));
    check_eq("cause", 32'(bus.rst_cause_o), 32'(e_cause));
    @(negedge clk_sys);
  endtask

  task automatic check_asserted(input string tag);
    check_eq({tag, "_dom"},   32'(bus.rst_dom_no),  32'(0));
    check_eq({tag, "_done"},  32'(bus.rst_done_o),  32'(0));
    check_eq({tag, "_cause"}, 32'(bus.rst_cause_o), 32'(2'b01));
  endtask

  task automatic drop_rst(input int k);
    rst_sys_n = 1'b0;
    model_async_reset();
    #1;
    check_asserted("async_drop");
    repeat (k) cycle();
    rst_sys_n = 1'b1;
  endtask

  task automatic glitch_rst();
    #1 rst_sys_n = 1'b0;
    model_async_reset();
    #1;
    check_asserted("glitch");
    rst_sys_n = 1'b1;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (bus.rst_done_o) break;
      cycle();
    end
    check_eq("wait_done", 32'(bus.rst_done_o), 32'(1));
  endtask

  initial begin
    int lat0, lat1, lat2;
    bus.soft_rst_req_i = 1'b0;
    bus.cause_clr_i    = 1'b0;
    model_async_reset();
    @(negedge clk_sys);
    #1;
    check_asserted("por");

    // Power-on release latencies.
    repeat (5) cycle();
    rst_sys_n = 1'b1;
    lat0 = 0; lat1 = 0; lat2 = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (bus.rst_dom_no[0] && lat0 == 0) lat0 = i;
      if (bus.rst_dom_no[1] && lat1 == 0) lat1 = i;
      if (bus.rst_dom_no[2] && lat2 == 0) lat2 = i;
    end
    check_eq("por_lat_d0", 32'(lat0), 32'(SS + H + 1));
    check_eq("por_lat_d1", 32'(lat1), 32'(SS + H + 1 + S));
    check_eq("por_lat_d2", 32'(lat2), 32'(SS + H + 1 + 2 * S));

    // Lock loss mid-sequence while in STEP.
    drop_rst(2);
    repeat (SS + H + 2) cycle();
    check_eq("mid_pre_drop", 32'(bus.rst_dom_no), 32'(3'b001));
    drop_rst(1);
    wait_done(60);

    // Soft request during STEP with domain 0 already released.
    drop_rst(2);
    repeat (SS + H + 2) cycle();
    bus.soft_rst_req_i = 1'b1;
    cycle();
    bus.soft_rst_req_i = 1'b0;
    check_eq("soft_step_dom", 32'(bus.rst_dom_no), 32'(3'b001));
    wait_done(60);

    // Soft reset from RUN racing a cause clear; then a lone clear.
    bus.soft_rst_req_i = 1'b1;
    bus.cause_clr_i    = 1'b1;
    cycle();
    bus.cause_clr_i    = 1'b0;
    check_eq("race_cause", 32'(bus.rst_cause_o), 32'(2'b10));
    check_eq("race_dom",   32'(bus.rst_dom_no),  32'(3'b001));
    repeat (2) cycle();
    bus.soft_rst_req_i = 1'b0;
    repeat (H + 1) cycle();
    check_eq("soft_rel_d1", 32'(bus.rst_dom_no), 32'(3'b011));
    repeat (S) cycle();
    check_eq("soft_rel_d2", 32'(bus.rst_dom_no), 32'(3'b111));
    bus.cause_clr_i = 1'b1;
    cycle();
    bus.cause_clr_i = 1'b0;
    check_eq("lone_clear", 32'(bus.rst_cause_o), 32'(2'b00));

    // Glitch shorter than a clock period.
    glitch_rst();
    repeat (SS) cycle();
    check_eq("glitch_hold", 32'(bus.rst_dom_no), 32'(0));
    wait_done(60);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.cause_clr_i = ($urandom_range(0, 19) == 0);
      if (bus.soft_rst_req_i) bus.soft_rst_req_i = ($urandom_range(0, 2) != 0);
      else bus.soft_rst_req_i = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 299))
        0: drop_rst(int'($urandom_range(1, 3)));
        1: glitch_rst();
        default: ;
      endcase
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
